// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encoding, default LATENCY/DEPTH and the processor address width.
package dmem_pkg;

  localparam int unsigned DefLatency = 2;
  localparam int unsigned DefDepth   = 64;
  localparam int unsigned AddrW      = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_byte_array.sv
// Big-endian byte storage with four byte lanes addressed from a single base address.
// Byte indices wrap modulo DEPTH; the storage is never reset.
// Ports:
//   clk   - clock, writes commit on the rising edge
//   we    - write all four bytes of wdata this edge
//   addr  - address of the most-significant byte
//   wdata - word to store, wdata[31:24] goes to byte[addr]
//   rdata - combinational read of the four bytes starting at addr
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [IdxW-1:0] idx [4];

  // IdxW-bit addition gives the modulo-DEPTH wrap for free.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = IdxW'(addr) + IdxW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        mem[idx[k]] <= wdata[31-8*k -: 8];
      end
    end
  end

  assign rdata = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder for a word-wide processor data port.
// A request is captured in IDLE (or on the edge ending an ack), waits LATENCY cycles,
// then completes with a one-cycle ack. Stores commit and load data is registered on
// the edge entering RESP.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag requests with addr[1:0] != 0;
// such requests complete with err=1, write nothing and return rdata=0.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (storage is not cleared)
//   req   - request, sampled in IDLE and on the edge ending the ack cycle
//   we    - 1 = store word, 0 = load word
//   addr  - byte address of the word's most-significant byte
//   wdata - store data
//   rdata - load data, valid while ack=1, held otherwise
//   ack   - one-cycle completion pulse
//   busy  - high whenever the FSM is not idle
//   err   - misalignment error, qualifies ack
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = DefLatency,
  parameter int unsigned DEPTH   = DefDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic             busy,
  output logic             err
);

  localparam logic [3:0] LatCnt = 4'(LATENCY);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [AddrW-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem_rdata;
  logic             accept;
  logic             commit;
  logic             misalign;
  logic             mem_we;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = LatCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // The edge ending the ack cycle may already start the next transaction.
        if (req) begin
          accept  = 1'b1;
          cnt_d   = LatCnt;
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit) begin
        rdata_q <= (we_q || misalign) ? 32'd0 : mem_rdata;
      end
    end
  end

  assign mem_we = commit && we_q && !misalign;

  dmem_byte_array #(
    .DEPTH(DEPTH)
  ) u_bytes (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign ack   = (state_q == StResp);
  assign busy  = (state_q != StIdle);
  assign err   = ack && misalign;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2 instance plus a LATENCY=0 one).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        req, we;
  logic [5:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack, busy, err;

  logic        req0, we0;
  logic [5:0]  addr0;
  logic [31:0] wdata0, rdata0;
  logic        ack0, busy0, err0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.LATENCY(2), .DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ack  (ack),
    .busy (busy),
    .err  (err)
  );

  dmem_responder #(.LATENCY(0), .DEPTH(64)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req0),
    .we   (we0),
    .addr (addr0),
    .wdata(wdata0),
    .rdata(rdata0),
    .ack  (ack0),
    .busy (busy0),
    .err  (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance: req is high only for the accepting edge and
  // the request fields are scrambled right after acceptance.
  task automatic xfer(input logic w, input logic [5:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
    lat = 0; rd = 'x; e = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ack) begin
        lat = n; rd = rdata; e = err;
        break;
      end
    end
    tick();
    chk("ack_single_pulse", {31'd0, ack}, 32'd0);
    chk("idle_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          acks;

    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Store then load at 0x04.
    xfer(1'b1, 6'h04, 32'hDEADBEEF, lat, rd, e);
    chk("st4_latency", 32'(lat), 32'd3);
    chk("st4_rdata_zero", rd, 32'd0);
    chk("st4_err", {31'd0, e}, 32'd0);
    chk("byte4", {24'd0, dut.u_bytes.mem[4]}, 32'hDE);
    chk("byte5", {24'd0, dut.u_bytes.mem[5]}, 32'hAD);
    chk("byte6", {24'd0, dut.u_bytes.mem[6]}, 32'hBE);
    chk("byte7", {24'd0, dut.u_bytes.mem[7]}, 32'hEF);
    xfer(1'b0, 6'h04, 32'h0, lat, rd, e);
    chk("ld4_latency", 32'(lat), 32'd3);
    chk("ld4_rdata", rd, 32'hDEADBEEF);
    chk("ld4_rdata_held", rdata, 32'hDEADBEEF);

    // Known contents at 0x08, then a store there cut short by reset.
    xfer(1'b1, 6'h08, 32'h01020304, lat, rd, e);
    chk("st8_latency", 32'(lat), 32'd3);
    req = 1'b1; we = 1'b1; addr = 6'h08; wdata = 32'hAAAAAAAA;
    tick();
    req = 1'b0;
    tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait_busy", {31'd0, busy}, 32'd0);
    chk("rstwait_ack", {31'd0, ack}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (ack) acks++;
    end
    chk("rstwait_no_ack", 32'(acks), 32'd0);
    xfer(1'b0, 6'h08, 32'h0, lat, rd, e);
    chk("ld8_after_rst", rd, 32'h01020304);

`ifdef DMEM_MISALIGN_ERR_EN
    xfer(1'b1, 6'h05, 32'hCAFEF00D, lat, rd, e);
    chk("mis_latency", 32'(lat), 32'd3);
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_byte5", {24'd0, dut.u_bytes.mem[5]}, 32'hAD);
    chk("mis_byte6", {24'd0, dut.u_bytes.mem[6]}, 32'hBE);
    chk("mis_byte7", {24'd0, dut.u_bytes.mem[7]}, 32'hEF);
    chk("mis_byte8", {24'd0, dut.u_bytes.mem[8]}, 32'h01);
`else
    xfer(1'b1, 6'd62, 32'h11223344, lat, rd, e);
    chk("wrap_err", {31'd0, e}, 32'd0);
    chk("wrap_byte62", {24'd0, dut.u_bytes.mem[62]}, 32'h11);
    chk("wrap_byte63", {24'd0, dut.u_bytes.mem[63]}, 32'h22);
    chk("wrap_byte0", {24'd0, dut.u_bytes.mem[0]}, 32'h33);
    chk("wrap_byte1", {24'd0, dut.u_bytes.mem[1]}, 32'h44);
    xfer(1'b0, 6'd62, 32'h0, lat, rd, e);
    chk("wrap_load", rd, 32'h11223344);
    xfer(1'b0, 6'h05, 32'h0, lat, rd, e);
    chk("unaligned_load", rd, 32'hADBEEF01);
    chk("unaligned_err", {31'd0, e}, 32'd0);
`endif

    // One-cycle req pulse still completes exactly once.
    req = 1'b1; we = 1'b0; addr = 6'h10;
    tick();
    req = 1'b0;
    acks = 0;
    repeat (8) begin
      tick();
      if (ack) acks++;
    end
    chk("pulse_one_ack", 32'(acks), 32'd1);

    // Continuous req with alternating addresses: acks at t0+3, 7, 11, 15.
    req = 1'b1; we = 1'b0; addr = 6'h04;
    tick();
    addr = 6'h08;
    acks = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("cont_ack_pos", {31'd0, ack}, (i % 4 == 3) ? 32'd1 : 32'd0);
      if (ack) begin
        chk("cont_rdata", rdata, (acks % 2 == 0) ? 32'hDEADBEEF : 32'h01020304);
        acks++;
      end
      if (i % 4 == 0) addr = (addr == 6'h04) ? 6'h08 : 6'h04;
      if (i == 15) req = 1'b0;
    end
    chk("cont_ack_count", 32'(acks), 32'd4);
    chk("cont_idle", {31'd0, busy}, 32'd0);

    // LATENCY=0: ack in the cycle after edge t0+1.
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h00; wdata0 = 32'h5A5AA5A5;
    tick();
    req0 = 1'b0; wdata0 = 32'h0;
    chk("l0_st_wait_ack", {31'd0, ack0}, 32'd0);
    chk("l0_st_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("l0_st_ack", {31'd0, ack0}, 32'd1);
    tick();
    chk("l0_st_ack_drop", {31'd0, ack0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h00;
    tick();
    req0 = 1'b0;
    chk("l0_ld_wait_ack", {31'd0, ack0}, 32'd0);
    tick();
    chk("l0_ld_ack", {31'd0, ack0}, 32'd1);
    chk("l0_ld_rdata", rdata0, 32'h5A5AA5A5);
    tick();
    chk("l0_ld_ack_drop", {31'd0, ack0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
